// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO push-port arbiter.
//   arb_state_t      : arbiter FSM encoding (idle / granted)
//   DEF_N_REQ        : default number of requesters
//   DEF_WIDTH        : default data width (matches the FIFO)
//   DEF_MAX_BURST    : default beat cap per grant
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int unsigned DEF_N_REQ     = 4;
  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   last  : index holding lowest priority; search starts at last+1 and wraps
//   valid : some request is asserted
//   idx   : index of the picked requester (0 when valid is low)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  // Walk N_REQ candidates starting after last; last itself is visited at the end.
  always_comb begin
    int unsigned cand;
    cand  = 0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = 32'(last) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among N_REQ producers.
// A grant is held per burst (up to MAX_BURST accepted beats) and the FIFO is
// never pushed while full.
//   clk, rst    : clock, asynchronous active-high reset
//   req         : per-requester request (level, held until accept)
//   req_data    : per-requester data word
//   fifo_full   : full flag from the FIFO
//   gnt         : registered one-hot grant, zero when idle
//   accept      : one-hot, owner's beat taken this cycle (combinational)
//   push        : FIFO push (combinational)
//   write_data  : FIFO write data, zero outside a grant (combinational)
//   owner       : index of the current or last owner
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0][WIDTH-1:0]  req_data,
  input  logic                         fifo_full,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             accept,
  output logic                         push,
  output logic [WIDTH-1:0]             write_data,
  output logic [$clog2(N_REQ)-1:0]     owner
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IDX_W-1:0] owner_n;
  logic [IDX_W-1:0] last_owner, last_owner_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
  logic [IDX_W-1:0] pick_last;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             release_grant;

  // Idle picks after last_owner; a handoff picks after the releasing owner,
  // so the owner only wins back the port when nobody else is requesting.
  assign pick_last = (state == ARB_GRANT) ? owner : last_owner;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .last  (pick_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      gnt        <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      beat_cnt   <= beat_cnt_n;
    end
  end

  // Next-state logic and combinational push path to the FIFO.
  always_comb begin
    state_n       = state;
    gnt_n         = gnt;
    owner_n       = owner;
    last_owner_n  = last_owner;
    beat_cnt_n    = beat_cnt;
    push          = 1'b0;
    accept        = '0;
    write_data    = '0;
    release_grant = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_n           = ARB_GRANT;
          gnt_n             = '0;
          gnt_n[pick_idx]   = 1'b1;
          owner_n           = pick_idx;
          beat_cnt_n        = '0;
        end else begin
          gnt_n = '0;
        end
      end

      ARB_GRANT: begin
        write_data    = req_data[owner];
        // Full only stalls the beat; it never ends the burst.
        push          = req[owner] & ~fifo_full;
        accept[owner] = push;
        if (push) begin
          beat_cnt_n = beat_cnt + CNT_W'(1);
        end
        release_grant = ~req[owner] | (push & (beat_cnt == LAST_BEAT));
        if (release_grant) begin
          last_owner_n = owner;
          beat_cnt_n   = '0;
          if (pick_valid) begin
            gnt_n           = '0;
            gnt_n[pick_idx] = 1'b1;
            owner_n         = pick_idx;
          end else begin
            state_n = ARB_IDLE;
            gnt_n   = '0;
          end
        end
      end

      default: begin
        state_n = ARB_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4)
// with a behavioural depth-8 FIFO and queue-driven producers.
module tb_fifo_push_arbiter;
  import fifo_arb_pkg::*;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [3:0][7:0] req_data;
  logic            fifo_full;
  logic [3:0]      gnt;
  logic [3:0]      accept;
  logic            push;
  logic [7:0]      write_data;
  logic [1:0]      owner;

  fifo_push_arbiter #(
    .N_REQ     (4),
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .fifo_full  (fifo_full),
    .gnt        (gnt),
    .accept     (accept),
    .push       (push),
    .write_data (write_data),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ovf      = 0;

  logic [7:0] src_q [4][$];
  logic [7:0] fmem [$];
  logic [7:0] exp_q [$];
  logic [3:0] en;
  logic [7:0] popped;
  logic [7:0] exp_wd;

  logic       s_push;
  logic [3:0] s_acc;
  logic [7:0] s_wd;
  logic [3:0] s_gnt;
  logic [1:0] s_owner;
  logic [2:0] s_cnt;
  arb_state_t s_state;

  task automatic apply_inputs();
    for (int r = 0; r < 4; r++) begin
      req[r]      = en[r] && (src_q[r].size() != 0);
      req_data[r] = (src_q[r].size() != 0) ? src_q[r][0] : 8'h00;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int r = 0; r < 4; r++) src_q[r].delete();
    fmem.delete();
    exp_q.delete();
    en        = 4'b1111;
    fifo_full = 1'b0;
    apply_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: sample mid-cycle, let the FIFO model and producers react to the edge.
  task automatic cycle(input logic do_pop);
    @(negedge clk);
    s_push  = push;
    s_acc   = accept;
    s_wd    = write_data;
    s_gnt   = gnt;
    s_owner = owner;
    s_cnt   = dut.beat_cnt;
    s_state = dut.state;
    @(posedge clk);
    if (do_pop && fmem.size() != 0) popped = fmem.pop_front();
    if (s_push) begin
      if (fmem.size() >= 8) ovf++;
      else fmem.push_back(s_wd);
    end
    #1;
    for (int r = 0; r < 4; r++) if (s_acc[r] && src_q[r].size() != 0) void'(src_q[r].pop_front());
    fifo_full = (fmem.size() == 8);
    apply_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    checks++; if (push !== 1'b0 || accept !== 4'b0000) begin failures++; $display("FAIL reset_push got=%b/%b want=0/0000", push, accept); end
    checks++; if (write_data !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h want=00", write_data); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d want=0", owner); end
    checks++; if (dut.last_owner !== 2'd3) begin failures++; $display("FAIL reset_last_owner got=%0d want=3", dut.last_owner); end
    checks++; if (dut.beat_cnt !== 3'd0 || dut.state !== ARB_IDLE) begin failures++; $display("FAIL reset_state got=%0d/%0d want=0/0", dut.beat_cnt, dut.state); end
  endtask

  task automatic test_basic_grant();
    apply_reset();
    src_q[2] = '{8'h21, 8'h22, 8'h23};
    exp_q    = '{8'h21, 8'h22, 8'h23};
    apply_inputs();
    cycle(1'b0);
    checks++; if (s_gnt !== 4'b0000 || s_push !== 1'b0) begin failures++; $display("FAIL basic_latency got=%b/%b want=0000/0", s_gnt, s_push); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      checks++; if (s_gnt !== 4'b0100 || s_acc !== 4'b0100) begin failures++; $display("FAIL basic_gnt beat=%0d got=%b/%b want=0100/0100", i, s_gnt, s_acc); end
      checks++;
      if (!s_push || exp_q.size() == 0) begin failures++; $display("FAIL basic_push beat=%0d got=%b want=1", i, s_push); end
      else begin exp_wd = exp_q.pop_front(); if (s_wd !== exp_wd) begin failures++; $display("FAIL basic_data beat=%0d got=%h want=%h", i, s_wd, exp_wd); end end
    end
    cycle(1'b0);
    checks++; if (s_push !== 1'b0) begin failures++; $display("FAIL basic_drop_push got=%b want=0", s_push); end
    cycle(1'b0);
    checks++; if (s_gnt !== 4'b0000) begin failures++; $display("FAIL basic_release_gnt got=%b want=0000", s_gnt); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      checks++; if (popped !== 8'(8'h21 + i)) begin failures++; $display("FAIL basic_pop idx=%0d got=%h want=%h", i, popped, 8'(8'h21 + i)); end
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_own;
    apply_reset();
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 8; j++) src_q[r].push_back(8'(r * 16 + j));
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 4; j++) exp_q.push_back(8'((b % 4) * 16 + (b / 4) * 4 + j));
    apply_inputs();
    cycle(1'b1);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1);
      exp_own = 2'((i / 4) % 4);
      checks++; if (s_owner !== exp_own || s_acc !== (4'b0001 << exp_own)) begin failures++; $display("FAIL fair_owner beat=%0d got=%0d/%b want=%0d", i, s_owner, s_acc, exp_own); end
      checks++;
      if (!s_push || exp_q.size() == 0) begin failures++; $display("FAIL fair_push beat=%0d got=%b want=1", i, s_push); end
      else begin exp_wd = exp_q.pop_front(); if (s_wd !== exp_wd) begin failures++; $display("FAIL fair_data beat=%0d got=%h want=%h", i, s_wd, exp_wd); end end
    end
    cycle(1'b1);
    checks++; if (s_push !== 1'b0) begin failures++; $display("FAIL fair_end_push got=%b want=0", s_push); end
  endtask

  task automatic test_burst_limit();
    apply_reset();
    for (int j = 1; j <= 6; j++) begin src_q[0].push_back(8'(j)); exp_q.push_back(8'(j)); end
    apply_inputs();
    cycle(1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1);
      checks++; if (s_gnt !== 4'b0001 || s_cnt !== 3'(i % 4)) begin failures++; $display("FAIL limit_gnt beat=%0d got=%b/%0d want=0001/%0d", i, s_gnt, s_cnt, i % 4); end
      checks++;
      if (!s_push || exp_q.size() == 0) begin failures++; $display("FAIL limit_push beat=%0d got=%b want=1", i, s_push); end
      else begin exp_wd = exp_q.pop_front(); if (s_wd !== exp_wd) begin failures++; $display("FAIL limit_data beat=%0d got=%h want=%h", i, s_wd, exp_wd); end end
    end
  endtask

  task automatic test_full_backpressure();
    apply_reset();
    for (int j = 0; j < 10; j++) begin src_q[1].push_back(8'(8'h10 + j)); exp_q.push_back(8'(8'h10 + j)); end
    apply_inputs();
    cycle(1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0);
      checks++;
      if (!s_push || exp_q.size() == 0) begin failures++; $display("FAIL full_fill_push beat=%0d got=%b want=1", i, s_push); end
      else begin exp_wd = exp_q.pop_front(); if (s_wd !== exp_wd) begin failures++; $display("FAIL full_fill_data beat=%0d got=%h want=%h", i, s_wd, exp_wd); end end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      checks++; if (s_push !== 1'b0 || s_acc !== 4'b0000) begin failures++; $display("FAIL full_stall_push cyc=%0d got=%b/%b want=0/0000", i, s_push, s_acc); end
      checks++; if (s_gnt !== 4'b0010 || s_cnt !== 3'd0) begin failures++; $display("FAIL full_hold cyc=%0d got=%b/%0d want=0010/0", i, s_gnt, s_cnt); end
    end
    cycle(1'b1);
    checks++; if (s_push !== 1'b0) begin failures++; $display("FAIL full_pop_cycle got=%b want=0", s_push); end
    cycle(1'b0);
    checks++;
    if (!s_push || exp_q.size() == 0) begin failures++; $display("FAIL full_resume_push got=%b want=1", s_push); end
    else begin exp_wd = exp_q.pop_front(); if (s_wd !== exp_wd) begin failures++; $display("FAIL full_resume_data got=%h want=%h", s_wd, exp_wd); end end
    cycle(1'b0);
    checks++; if (s_push !== 1'b0) begin failures++; $display("FAIL full_single_push got=%b want=0", s_push); end
    checks++; if (ovf !== 0) begin failures++; $display("FAIL full_overflow got=%0d want=0", ovf); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    src_q[3] = '{8'h30, 8'h31, 8'h32, 8'h33};
    apply_inputs();
    cycle(1'b0);
    cycle(1'b0);
    checks++; if (s_push !== 1'b1 || s_wd !== 8'h30) begin failures++; $display("FAIL rstmid_first got=%b/%h want=1/30", s_push, s_wd); end
    #2;
    checks++; if (push !== 1'b1 || accept !== 4'b1000) begin failures++; $display("FAIL rstmid_inflight got=%b/%b want=1/1000", push, accept); end
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000 || push !== 1'b0 || accept !== 4'b0000) begin failures++; $display("FAIL rstmid_clear got=%b/%b/%b want=0000/0/0000", gnt, push, accept); end
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) begin src_q[r].delete(); src_q[r].push_back(8'(r * 16 + 5)); end
    exp_q.delete();
    exp_q.push_back(8'h05);
    apply_inputs();
    rst = 1'b0;
    cycle(1'b0);
    checks++; if (s_gnt !== 4'b0000) begin failures++; $display("FAIL rstmid_idle got=%b want=0000", s_gnt); end
    cycle(1'b0);
    checks++; if (s_gnt !== 4'b0001 || s_owner !== 2'd0) begin failures++; $display("FAIL rstmid_first_gnt got=%b/%0d want=0001/0", s_gnt, s_owner); end
    checks++;
    if (!s_push || exp_q.size() == 0) begin failures++; $display("FAIL rstmid_push got=%b want=1", s_push); end
    else begin exp_wd = exp_q.pop_front(); if (s_wd !== exp_wd) begin failures++; $display("FAIL rstmid_data got=%h want=%h", s_wd, exp_wd); end end
  endtask

  task automatic test_drop_handoff();
    logic       exp_push [8];
    logic [3:0] exp_gnt  [8];
    exp_push = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_gnt  = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    apply_reset();
    src_q[1] = '{8'h40, 8'h41};
    src_q[2] = '{8'h50, 8'h51};
    exp_q    = '{8'h40, 8'h41, 8'h50, 8'h51};
    apply_inputs();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0);
      checks++; if (s_gnt !== exp_gnt[i] || s_push !== exp_push[i]) begin failures++; $display("FAIL drop_seq cyc=%0d got=%b/%b want=%b/%b", i, s_gnt, s_push, exp_gnt[i], exp_push[i]); end
      if (exp_push[i] && s_push) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL drop_extra_push cyc=%0d got=%h want=none", i, s_wd); end
        else begin exp_wd = exp_q.pop_front(); if (s_wd !== exp_wd) begin failures++; $display("FAIL drop_data cyc=%0d got=%h want=%h", i, s_wd, exp_wd); end end
      end
    end
    checks++; if (s_state !== ARB_IDLE) begin failures++; $display("FAIL drop_idle_state got=%0d want=%0d", s_state, ARB_IDLE); end
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    en        = 4'b1111;
    popped    = '0;
    exp_wd    = '0;
    test_reset();
    test_basic_grant();
    test_fairness();
    test_burst_limit();
    test_full_backpressure();
    test_reset_mid_burst();
    test_drop_handoff();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
